// File: rtl/mcu_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu_dbg_pkg
// Purpose  : Shared state encodings and halt-cause codes for the MCU
//            run/reset controller and its breakpoint matcher.
// Revision : 1.0 - initial release
// ============================================================================
package mcu_dbg_pkg;

   // Controller states; encodings are visible to debug tooling, keep fixed.
   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_t;

   // Reason reported for the most recent halt.
   localparam logic [1:0] c_cause_none = 2'd0;
   localparam logic [1:0] c_cause_req  = 2'd1;
   localparam logic [1:0] c_cause_bp   = 2'd2;
   localparam logic [1:0] c_cause_step = 2'd3;

endpackage : mcu_dbg_pkg
`default_nettype wire

// File: rtl/mcu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mcu_run_ctrl_if
// Purpose  : Debug/run-control bundle between the board debug side, the
//            microcontroller core and the run controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mcu_run_ctrl_if #(
   parameter int PC_W   = 8,
   parameter int NUM_BP = 2,
   parameter int STEP_W = 8,
   parameter int CNT_W  = 32
);
   logic                     run_req;
   logic                     halt_req;
   logic                     step_req;
   logic [STEP_W-1:0]        step_n;
   logic                     instr_done;
   logic [PC_W-1:0]          pc;
   logic [NUM_BP-1:0]        bp_en;
   logic [NUM_BP*PC_W-1:0]   bp_addr;
   logic                     core_rst;
   logic                     core_en;
   logic                     halted;
   logic [1:0]               halt_cause;
   logic [NUM_BP-1:0]        bp_hit;
   logic [CNT_W-1:0]         cycle_cnt;

   // Debug host / core side: issues requests and instruction status.
   modport master (
      output run_req, halt_req, step_req, step_n, instr_done, pc, bp_en, bp_addr,
      input  core_rst, core_en, halted, halt_cause, bp_hit, cycle_cnt
   );

   // Run controller side.
   modport slave (
      input  run_req, halt_req, step_req, step_n, instr_done, pc, bp_en, bp_addr,
      output core_rst, core_en, halted, halt_cause, bp_hit, cycle_cnt
   );
endinterface : mcu_run_ctrl_if
`default_nettype wire

// File: rtl/mcu_bp_match.sv
`default_nettype none
// ============================================================================
// Module   : mcu_bp_match
// Purpose  : Combinational PC breakpoint comparator. Flags any enabled match
//            and returns a one-hot of the lowest-index matching breakpoint.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_bp_match #(
   parameter int PC_W   = 8,
   parameter int NUM_BP = 2
) (
   input  wire logic [PC_W-1:0]        i_pc,
   input  wire logic [NUM_BP-1:0]      i_bp_en,
   input  wire logic [NUM_BP*PC_W-1:0] i_bp_addr,
   output logic                        o_match,
   output logic [NUM_BP-1:0]           o_hit
);

   localparam logic [NUM_BP-1:0] c_one = NUM_BP'(1);

   logic [NUM_BP-1:0] w_eq;

   // Per-breakpoint compare against the current PC.
   for (genvar g = 0; g < NUM_BP; g++) begin : g_bp
      assign w_eq[g] = i_bp_en[g] && (i_bp_addr[g*PC_W +: PC_W] == i_pc);
   end

   // x & -x isolates the lowest set bit, giving lowest-index priority.
   assign o_hit   = w_eq & (~w_eq + c_one);
   assign o_match = |w_eq;

endmodule : mcu_bp_match
`default_nettype wire

// File: rtl/mcu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mcu_run_ctrl
// Purpose  : Reset stretcher and run/halt/single-step controller for the
//            8-bit multi-cycle MCU, with PC breakpoints and a saturating
//            count of enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_run_ctrl
   import mcu_dbg_pkg::*;
#(
   parameter int RST_STRETCH = 5,
   parameter int AUTO_RUN    = 1,
   parameter int PC_W        = 8,
   parameter int NUM_BP      = 2,
   parameter int STEP_W      = 8,
   parameter int CNT_W       = 32
) (
   input  wire logic      clk,
   input  wire logic      rs,
   mcu_run_ctrl_if.slave  bus
);

   localparam logic [7:0]        c_stretch  = 8'(RST_STRETCH);
   localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);
   localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

   state_t              r_state, w_state_nx;
   logic [7:0]          r_stretch, w_stretch_nx;
   logic [STEP_W-1:0]   r_rem, w_rem_nx;
   logic                r_pend, w_pend_nx;
   logic                r_first, w_first_nx;
   logic [1:0]          r_cause, w_cause_nx;
   logic [NUM_BP-1:0]   r_bp_hit, w_bp_hit_nx;
   logic                r_core_rst, r_core_en, r_halted;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_match;
   logic [NUM_BP-1:0]   w_hit;
   logic                w_pend_now;
   logic                w_bp_ok;

   mcu_bp_match #(
      .PC_W   (PC_W),
      .NUM_BP (NUM_BP)
   ) u_bp_match (
      .i_pc      (bus.pc),
      .i_bp_en   (bus.bp_en),
      .i_bp_addr (bus.bp_addr),
      .o_match   (w_match),
      .o_hit     (w_hit)
   );

   // A halt request in the same cycle as instr_done applies to that boundary;
   // breakpoints are ignored on the first boundary after a resume so the core
   // can step off the instruction it stopped at.
   assign w_pend_now = r_pend | bus.halt_req;
   assign w_bp_ok    = w_match & ~r_first;

   // Next-state logic for the run-control FSM and its side counters.
   always_comb begin
      w_state_nx   = r_state;
      w_stretch_nx = r_stretch;
      w_rem_nx     = r_rem;
      w_pend_nx    = r_pend;
      w_first_nx   = r_first;
      w_cause_nx   = r_cause;
      w_bp_hit_nx  = r_bp_hit;

      unique case (r_state)
         ST_RST: begin
            if (r_stretch <= 8'd1) begin
               w_state_nx = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
            end else begin
               w_stretch_nx = r_stretch - 8'd1;
            end
         end

         ST_HALT: begin
            if (bus.step_req || bus.run_req) begin
               w_state_nx  = bus.step_req ? ST_STEP : ST_RUN;
               w_rem_nx    = (bus.step_n == '0) ? c_step_one : bus.step_n;
               w_cause_nx  = c_cause_none;
               w_bp_hit_nx = '0;
               w_pend_nx   = 1'b0;
               w_first_nx  = 1'b1;
            end
         end

         ST_RUN, ST_STEP: begin
            w_pend_nx = w_pend_now;
            if (bus.instr_done) begin
               w_first_nx = 1'b0;
               w_rem_nx   = r_rem - c_step_one;
               if (w_pend_now) begin
                  w_state_nx = ST_HALT;
                  w_cause_nx = c_cause_req;
                  w_pend_nx  = 1'b0;
               end else if (w_bp_ok) begin
                  w_state_nx  = ST_HALT;
                  w_cause_nx  = c_cause_bp;
                  w_bp_hit_nx = w_hit;
               end else if ((r_state == ST_STEP) && (r_rem == c_step_one)) begin
                  w_state_nx = ST_HALT;
                  w_cause_nx = c_cause_step;
               end
            end
         end

         default: begin
            w_state_nx = ST_RST;
         end
      endcase
   end

   // State and registered outputs; rs forces the reset state immediately.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         r_state    <= ST_RST;
         r_stretch  <= c_stretch;
         r_rem      <= '0;
         r_pend     <= 1'b0;
         r_first    <= 1'b0;
         r_cause    <= c_cause_none;
         r_bp_hit   <= '0;
         r_core_rst <= 1'b1;
         r_core_en  <= 1'b0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_stretch  <= w_stretch_nx;
         r_rem      <= w_rem_nx;
         r_pend     <= w_pend_nx;
         r_first    <= w_first_nx;
         r_cause    <= w_cause_nx;
         r_bp_hit   <= w_bp_hit_nx;
         r_core_rst <= (w_state_nx == ST_RST);
         r_core_en  <= (w_state_nx == ST_RUN) || (w_state_nx == ST_STEP);
         r_halted   <= (w_state_nx == ST_HALT);
      end
   end

   // Saturating count of cycles in which the core was enabled.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         r_cnt <= '0;
      end else if (r_core_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + c_cnt_one;
      end
   end

   assign bus.core_rst   = r_core_rst;
   assign bus.core_en    = r_core_en;
   assign bus.halted     = r_halted;
   assign bus.halt_cause = r_cause;
   assign bus.bp_hit     = r_bp_hit;
   assign bus.cycle_cnt  = r_cnt;

endmodule : mcu_run_ctrl
`default_nettype wire

// File: tb/tb_mcu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcu_run_ctrl
// Purpose  : Directed self-checking bench for mcu_run_ctrl. Instance A uses
//            AUTO_RUN=1, CNT_W=32; instance B uses AUTO_RUN=0, CNT_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_run_ctrl;

   logic clk = 1'b0;
   logic rs;
   int   checks = 0;
   int   errors = 0;

   mcu_run_ctrl_if #(.PC_W(8), .NUM_BP(2), .STEP_W(8), .CNT_W(32)) a_if ();
   mcu_run_ctrl_if #(.PC_W(8), .NUM_BP(2), .STEP_W(8), .CNT_W(4))  b_if ();

   mcu_run_ctrl #(
      .RST_STRETCH(5), .AUTO_RUN(1), .PC_W(8), .NUM_BP(2), .STEP_W(8), .CNT_W(32)
   ) u_dut_a (
      .clk (clk),
      .rs  (rs),
      .bus (a_if.slave)
   );

   mcu_run_ctrl #(
      .RST_STRETCH(5), .AUTO_RUN(0), .PC_W(8), .NUM_BP(2), .STEP_W(8), .CNT_W(4)
   ) u_dut_b (
      .clk (clk),
      .rs  (rs),
      .bus (b_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus to instance A; pulses are cleared afterwards.
   task automatic a_cyc(input logic done, input logic [7:0] p, input logic hreq,
                        input logic rreq, input logic sreq, input logic [7:0] n);
      a_if.instr_done = done;
      a_if.pc         = p;
      a_if.halt_req   = hreq;
      a_if.run_req    = rreq;
      a_if.step_req   = sreq;
      a_if.step_n     = n;
      tick();
      a_if.instr_done = 1'b0;
      a_if.halt_req   = 1'b0;
      a_if.run_req    = 1'b0;
      a_if.step_req   = 1'b0;
   endtask

   initial begin
      rs = 1'b0;
      a_if.run_req = 1'b0; a_if.halt_req = 1'b0; a_if.step_req = 1'b0;
      a_if.step_n = 8'd0; a_if.instr_done = 1'b0; a_if.pc = 8'd0;
      a_if.bp_en = 2'b00; a_if.bp_addr = 16'h0000;
      b_if.run_req = 1'b0; b_if.halt_req = 1'b0; b_if.step_req = 1'b0;
      b_if.step_n = 8'd0; b_if.instr_done = 1'b0; b_if.pc = 8'd0;
      b_if.bp_en = 2'b00; b_if.bp_addr = 16'h0000;

      // Asynchronous reset, checked before any clock edge.
      #2 rs = 1'b1;
      #1;
      chk("rst_core_rst", 32'(a_if.core_rst), 32'd1);
      chk("rst_core_en",  32'(a_if.core_en), 32'd0);
      chk("rst_halted",   32'(a_if.halted), 32'd0);
      chk("rst_cause",    32'(a_if.halt_cause), 32'd0);
      chk("rst_bp_hit",   32'(a_if.bp_hit), 32'd0);
      chk("rst_cnt",      a_if.cycle_cnt, 32'd0);

      // Release at t=100; core_rst must fall on the 5th rising edge.
      #97 rs = 1'b0;
      repeat (4) tick();
      chk("stretch4_core_rst", 32'(a_if.core_rst), 32'd1);
      chk("stretch4_core_en",  32'(a_if.core_en), 32'd0);
      tick();
      chk("stretch5_core_rst", 32'(a_if.core_rst), 32'd0);
      chk("stretch5_core_en",  32'(a_if.core_en), 32'd1);
      chk("stretch5_halted",   32'(a_if.halted), 32'd0);
      chk("b_stretch5_core_rst", 32'(b_if.core_rst), 32'd0);
      chk("b_stretch5_halted",   32'(b_if.halted), 32'd1);
      chk("b_stretch5_core_en",  32'(b_if.core_en), 32'd0);
      chk("b_stretch5_cnt",      32'(b_if.cycle_cnt), 32'd0);

      // Halt request in cycle 2 of a 4-cycle instruction.
      a_cyc(1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("hreq_wait_core_en", 32'(a_if.core_en), 32'd1);
      chk("hreq_wait_halted",  32'(a_if.halted), 32'd0);
      a_cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("hreq_core_en", 32'(a_if.core_en), 32'd0);
      chk("hreq_halted",  32'(a_if.halted), 32'd1);
      chk("hreq_cause",   32'(a_if.halt_cause), 32'd1);
      chk("hreq_cnt",     a_if.cycle_cnt, 32'd4);

      // Breakpoint 1 at 0x1A.
      a_if.bp_en   = 2'b10;
      a_if.bp_addr = {8'h1A, 8'h00};
      a_cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h18, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h19, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("bp_19_halted", 32'(a_if.halted), 32'd0);
      a_cyc(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("bp_1a_halted", 32'(a_if.halted), 32'd1);
      chk("bp_1a_cause",  32'(a_if.halt_cause), 32'd2);
      chk("bp_1a_hit",    32'(a_if.bp_hit), 32'd2);
      chk("bp_1a_cnt",    a_if.cycle_cnt, 32'd7);

      // Resume from the breakpoint: first boundary at 0x1A must not re-halt.
      a_cyc(1'b0, 8'h1A, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("resume_cause",   32'(a_if.halt_cause), 32'd0);
      chk("resume_bp_hit",  32'(a_if.bp_hit), 32'd0);
      chk("resume_core_en", 32'(a_if.core_en), 32'd1);
      a_cyc(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("resume_no_rehalt", 32'(a_if.halted), 32'd0);
      a_cyc(1'b1, 8'h1B, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("bp_again_halted", 32'(a_if.halted), 32'd1);
      chk("bp_again_cause",  32'(a_if.halt_cause), 32'd2);
      chk("bp_again_cnt",    a_if.cycle_cnt, 32'd10);

      // Both breakpoints match: lowest index wins.
      a_if.bp_en   = 2'b11;
      a_if.bp_addr = {8'h1A, 8'h1A};
      a_cyc(1'b0, 8'h1A, 1'b0, 1'b1, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("bp_prio_hit",   32'(a_if.bp_hit), 32'd1);
      chk("bp_prio_cause", 32'(a_if.halt_cause), 32'd2);

      // Step 3 two-cycle instructions; run_req inside STEP is ignored.
      a_if.bp_en = 2'b00;
      a_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd3);
      chk("step3_core_en", 32'(a_if.core_en), 32'd1);
      a_cyc(1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("step3_after2_halted", 32'(a_if.halted), 32'd0);
      a_cyc(1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("step3_halted", 32'(a_if.halted), 32'd1);
      chk("step3_cause",  32'(a_if.halt_cause), 32'd3);
      chk("step3_cnt",    a_if.cycle_cnt, 32'd18);

      // step_n = 0 executes exactly one instruction.
      a_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);
      chk("step0_halted_before", 32'(a_if.halted), 32'd0);
      a_cyc(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("step0_halted", 32'(a_if.halted), 32'd1);
      chk("step0_cause",  32'(a_if.halt_cause), 32'd3);
      chk("step0_cnt",    a_if.cycle_cnt, 32'd19);

      // Final step boundary with halt_req and breakpoint: request wins.
      a_if.bp_en   = 2'b01;
      a_if.bp_addr = {8'h00, 8'h30};
      a_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2);
      a_cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 8'd0);
      chk("prio_req_halted", 32'(a_if.halted), 32'd1);
      chk("prio_req_cause",  32'(a_if.halt_cause), 32'd1);
      chk("prio_req_bp_hit", 32'(a_if.bp_hit), 32'd0);

      // Final step boundary with breakpoint only: breakpoint beats step done.
      a_cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2);
      a_cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'd0);
      a_cyc(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("prio_bp_cause",  32'(a_if.halt_cause), 32'd2);
      chk("prio_bp_bp_hit", 32'(a_if.bp_hit), 32'd1);

      // Saturation on the 4-bit counter of instance B.
      b_if.run_req = 1'b1;
      tick();
      b_if.run_req = 1'b0;
      chk("b_run_core_en", 32'(b_if.core_en), 32'd1);
      chk("b_run_cnt0",    32'(b_if.cycle_cnt), 32'd0);
      repeat (5) tick();
      chk("b_cnt5", 32'(b_if.cycle_cnt), 32'd5);
      repeat (15) tick();
      chk("b_cnt_sat", 32'(b_if.cycle_cnt), 32'hF);

      // Reset mid-instruction takes effect without a clock edge.
      a_cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0);
      a_cyc(1'b0, 8'h40, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("pre_rs_core_en", 32'(a_if.core_en), 32'd1);
      #3 rs = 1'b1;
      #1;
      chk("async_core_rst", 32'(a_if.core_rst), 32'd1);
      chk("async_core_en",  32'(a_if.core_en), 32'd0);
      chk("async_halted",   32'(a_if.halted), 32'd0);
      chk("async_cnt",      a_if.cycle_cnt, 32'd0);
      chk("async_b_core_en", 32'(b_if.core_en), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mcu_run_ctrl
`default_nettype wire

// File: doc/mcu_run_ctrl.md
Name: mcu_run_ctrl

Overview:
Synthesizable run/reset controller for the 8-bit multi-cycle microcontroller. It generalises the bench-style reset sequencing into hardware: it stretches reset and gates core execution through a clock enable. It also provides run/halt/single-step control, PC breakpoints and a cycle counter. It sits between the board-level reset/debug inputs and the microcontroller's reset and enable inputs.

Parameters:
RST_STRETCH, 5, cycles core_rst stays high after rs deasserts (1..255)
AUTO_RUN, 1, 1 = enter RUN after reset stretch, 0 = enter HALT
PC_W, 8, program counter width
NUM_BP, 2, number of PC breakpoints (1..4)
STEP_W, 8, width of step count
CNT_W, 32, width of executed-cycle counter

Ports:
clk  in  1  system clock, rising edge
rs  in  1  asynchronous active-high reset
run_req  in  1  pulse: resume execution
halt_req  in  1  pulse: stop at next instruction boundary
step_req  in  1  pulse: execute step_n instructions then halt
step_n  in  STEP_W  instruction count for step_req (0 treated as 1)
instr_done  in  1  core pulse, last cycle of each instruction
pc  in  PC_W  core PC of next instruction, valid when instr_done=1
bp_en  in  NUM_BP  per-breakpoint enable
bp_addr  in  NUM_BP*PC_W  breakpoint addresses, bp i at [i*PC_W +: PC_W]
core_rst  out  1  reset to microcontroller
core_en  out  1  execution enable to microcontroller
halted  out  1  state==HALT
halt_cause  out  2  0 none, 1 request, 2 breakpoint, 3 step done
bp_hit  out  NUM_BP  one-hot of breakpoint that caused last halt
cycle_cnt  out  CNT_W  count of cycles with core_en=1, saturating

Behaviour:
- All outputs are registered. rs asserted (async) sets the following: state=RST, core_rst=1, core_en=0, halted=0, halt_cause=0, bp_hit=0, cycle_cnt=0, stretch counter=RST_STRETCH.
- RST: the counter decrements each clk while rs=0. core_rst falls on exactly the RST_STRETCH-th rising edge after rs release. On that same edge the next state is RUN (AUTO_RUN=1) or HALT (AUTO_RUN=0), with core_en=1 for RUN.
- core_en=1 exactly when state is RUN or STEP. Transitions take effect on the edge after the causing event (1-cycle latency).
- RUN:
  - A halt_req pulse sets halt_pend.
  - On instr_done with halt_pend=1, the next state is HALT with cause 1.
  - Otherwise, on instr_done with an enabled bp_addr[i]==pc, the next state is HALT with cause 2 and bp_hit set; the lowest index wins if several match.
  - Halts occur only at instruction boundaries. A halt never truncates a multi-cycle instruction.
- HALT:
  - Priority is step_req > run_req.
  - step_req loads remaining=max(step_n,1) and enters STEP. run_req enters RUN.
  - Entering RUN or STEP clears halt_cause, bp_hit and halt_pend.
  - halt_req in HALT is ignored.
- STEP:
  - remaining decrements on each instr_done.
  - When instr_done arrives with remaining==1, the next state is HALT with cause 3.
  - Priority on the same instr_done is halt request (1) > breakpoint (2) > step done (3).
  - run_req and step_req are ignored in STEP.
- Breakpoint match is suppressed on the first instr_done after leaving HALT. This lets a resume from a breakpoint make progress.
- cycle_cnt increments on every cycle with core_en=1 and saturates at all-ones. It is not cleared by halt.
- A halt_req arriving in the same cycle as instr_done counts for that boundary.
- rs mid-instruction or mid-step forces RST immediately, with no boundary wait.

Decomposition:
- Shared package mcu_dbg_pkg holds:
  - state encodings: RST=2'd0, HALT=2'd1, RUN=2'd2, STEP=2'd3
  - halt_cause constants
- One sub-module, mcu_bp_match, is natural. It is combinational and parametrised by NUM_BP and PC_W. It outputs a match flag and a one-hot bp_hit using lowest-index priority.
- The FSM, stretch counter, step counter and cycle counter live in the top module.

Test Plan:
- Reset stretch: hold rs 100 ns, release. With RST_STRETCH=5, core_rst must fall on the 5th rising edge, with core_en=1 on that same edge. With AUTO_RUN=0, halted=1 instead.
- Halt at boundary: drive a 4-cycle instruction pattern and pulse halt_req in cycle 2. core_en must fall the cycle after the next instr_done, with halt_cause=1 and cycle_cnt advanced by exactly the enabled cycles.
- Breakpoint:
  - Set bp_en=2'b10, bp_addr[1]=8'h1A, and feed pc sequence 18,19,1A. Expect a halt after the instr_done with pc=1A, with halt_cause=2 and bp_hit=2'b10.
  - Then run_req: the first instr_done at 1A must not re-halt.
- Step:
  - From HALT, step_req with step_n=3 gives exactly 3 instr_done pulses, then halted with halt_cause=3.
  - step_n=0 gives 1 instruction.
- Priority and async reset:
  - Pulse halt_req during STEP on the final instr_done; expect cause 1.
  - Assert rs mid-instruction; core_rst=1 and core_en=0 must follow without waiting for a clock edge.
- Saturation: with CNT_W=4, run 20 cycles; expect cycle_cnt=4'hF.
